multi_ch_clk_div: RTL and testbench
===================================

Name: multi_ch_clk_div

Overview:
- N_CH-channel programmable clock divider, all channels clocked by clk_in.
- Each channel has its own runtime-configurable period and duty, a per-channel enable and a wrap tick.
- Config updates are glitch-free: a new config takes effect only at a period boundary or while the channel is idle.
- A global sync_start phase-aligns all channels. It replaces fixed-parameter single-output dividers in clock/strobe generation for slow peripherals.

Parameters:
- CNT_W, 26, width of counters and of the period/duty fields.
- N_CH, 4, number of output channels (1..16).
- CH_W, 2, width of cfg_ch; must be at least clog2(N_CH), minimum 1.
- DEF_PERIOD, 5, reset value of every channel's active period.
- DEF_DUTY, 2, reset value of every channel's active duty.

Ports:
- rst_n  input  1  asynchronous active-low reset.
- clk_in  input  1  clock; all logic is on the rising edge.
- cfg_we  input  1  config write strobe, one cycle.
- cfg_ch  input  CH_W  channel index for the write; writes with index >= N_CH are ignored.
- cfg_period  input  CNT_W  new period (divide ratio = period+1).
- cfg_duty  input  CNT_W  new duty threshold.
- ch_en  input  N_CH  per-channel run enable, level.
- sync_start  input  1  one-cycle global phase-align strobe.
- clk_out  output  N_CH  divided outputs, registered.
- tick  output  N_CH  one-cycle pulse per channel at each wrap, registered.
- cfg_pending  output  N_CH  high while a written config awaits application.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk_in.
- Reset values:
  - cnt = 0, running = 0, clk_out = 0, tick = 0, cfg_pending = 0.
  - act_period = DEF_PERIOD, act_duty = DEF_DUTY.
  - pending registers = 0.
- Per channel, state IDLE / RUN (running flag).
- IDLE:
  - cnt held at 0; clk_out <= 0; tick <= 0.
  - A pending config is applied in any IDLE cycle.
  - IDLE -> RUN when ch_en[i] = 1 is sampled; the first increment happens in the following cycle.
- RUN, every cycle:
  - wrap = (cnt >= act_period).
  - cnt <= wrap ? 0 : cnt+1.
  - clk_out <= (cnt > act_duty).
  - tick <= wrap.
- Output shape with period P and duty D, where D < P:
  - low for D+1 cycles, high for P-D cycles, period P+1 cycles.
  - Example: P=5, D=2 gives 3 low / 3 high.
- Degenerate configs, all without error:
  - D >= P: clk_out stays 0.
  - P = 0: clk_out stays 0 and tick is asserted every cycle.
- RUN -> IDLE only at a wrap cycle with ch_en[i] = 0. The current period always completes, and clk_out ends low (cleared on the next cycle).
- Config write:
  - cfg_we latches cfg_period/cfg_duty into channel cfg_ch's pending register and sets cfg_pending.
  - Apply happens at a wrap cycle in RUN, or in any IDLE cycle. act_* <= pending; cfg_pending cleared in the same cycle.
  - The wrap comparison in the apply cycle uses the old act_period.
  - A second write before apply overwrites the pending value; the last write wins.
  - A write in the same cycle as an apply bypasses: the written value is what is applied, and cfg_pending ends 0.
- sync_start, applied to every channel, highest priority:
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - pending configs applied (including a same-cycle write, by bypass).
  - running <= ch_en[i].
  - Enabled channels therefore restart in phase from the next cycle.
- Channels are fully independent except for sync_start and the shared config bus.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously), including active configs reverting to DEF_*.

Test Plan:
- Reset release, ch_en=0001, no writes -> clk_out[0] is 3 low / 3 high repeating, tick[0] every 6 cycles; other channels stay 0.
- cfg write ch0 P=9, D=4 mid-period -> cfg_pending[0] high until the next tick[0]; the current 6-cycle period completes; then 5 low / 5 high, period 10.
- ch1 P=3, D=3, then P=0 -> clk_out[1] constantly 0; tick[1] every 4 cycles, then every cycle.
- ch_en[0] dropped when cnt=1 -> the period finishes; clk_out[0] 0 after the wrap, no further tick; re-enable -> first clk_out rise D+2 cycles after ch_en is sampled.
- ch0 P=5, ch2 P=11 running with arbitrary phase; pulse sync_start -> both low the cycle after; rising edges coincide every 12 cycles.
- Assert rst_n low mid-high phase with a pending write -> outputs are 0 immediately; after release, default div-6 behaviour resumes and the pending write is lost.

Source files
------------

// File: rtl/multi_ch_clk_div.sv
// ---------------------------------------------------------------------------
// multi_ch_clk_div
//   N_CH-channel programmable clock divider. Every channel counts clk_in
//   cycles from 0 to its active period and drives a registered divided clock
//   plus a one-cycle wrap tick. New period/duty values are written through a
//   shared config bus into a per-channel pending register. They only take
//   effect at a period boundary or while the channel is idle, so an output
//   never sees a truncated or stretched phase. A global sync_start restarts
//   all channels in phase.
//
// Ports
//   rst_n        in   1      asynchronous active-low reset
//   clk_in       in   1      clock, rising edge
//   cfg_we       in   1      config write strobe (one cycle)
//   cfg_ch       in   CH_W   target channel; indices >= N_CH are ignored
//   cfg_period   in   CNT_W  new period (divide ratio = period+1)
//   cfg_duty     in   CNT_W  new duty threshold (low for duty+1 cycles)
//   ch_en        in   N_CH   per-channel run enable (level)
//   sync_start   in   1      one-cycle global phase-align strobe
//   clk_out      out  N_CH   divided clocks, registered
//   tick         out  N_CH   one-cycle pulse at each wrap, registered
//   cfg_pending  out  N_CH   a written config is waiting to be applied
// ---------------------------------------------------------------------------
module multi_ch_clk_div #(
  parameter int CNT_W      = 26,
  parameter int N_CH       = 4,
  parameter int CH_W       = 2,
  parameter int DEF_PERIOD = 5,
  parameter int DEF_DUTY   = 2
) (
  input  logic              rst_n,
  input  logic              clk_in,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync_start,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   cfg_pending
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] r_act_period;
      logic [CNT_W-1:0] r_act_duty;
      logic [CNT_W-1:0] r_pend_period;
      logic [CNT_W-1:0] r_pend_duty;
      logic             r_pend;
      logic             r_running;
      logic             r_clk;
      logic             r_tick;

      logic             w_wr;
      logic             w_wrap;
      logic             w_apply;
      logic [CNT_W-1:0] w_new_period;
      logic [CNT_W-1:0] w_new_duty;

      assign w_wr   = cfg_we && (cfg_ch == CH_W'(gi));
      // Compared against the config active this cycle; a same-cycle apply
      // only affects the following period.
      assign w_wrap = (r_cnt >= r_act_period);
      // Safe points to swap configs: period boundary, idle, or phase realign.
      assign w_apply = sync_start || !r_running || w_wrap;

      // A write landing on an apply cycle bypasses the pending register.
      assign w_new_period = w_wr ? cfg_period : r_pend_period;
      assign w_new_duty   = w_wr ? cfg_duty   : r_pend_duty;

      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt         <= '0;
          r_act_period  <= CNT_W'(DEF_PERIOD);
          r_act_duty    <= CNT_W'(DEF_DUTY);
          r_pend_period <= '0;
          r_pend_duty   <= '0;
          r_pend        <= 1'b0;
          r_running     <= 1'b0;
          r_clk         <= 1'b0;
          r_tick        <= 1'b0;
        end else begin
          if (w_wr) begin
            r_pend_period <= cfg_period;
            r_pend_duty   <= cfg_duty;
          end

          if (w_apply) begin
            if (w_wr || r_pend) begin
              r_act_period <= w_new_period;
              r_act_duty   <= w_new_duty;
            end
            r_pend <= 1'b0;
          end else if (w_wr) begin
            r_pend <= 1'b1;
          end

          if (sync_start || !r_running) begin
            // Idle or realign: counter parked at 0, first increment next cycle.
            r_cnt     <= '0;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
            r_running <= ch_en[gi];
          end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_clk  <= (r_cnt > r_act_duty);
            r_tick <= w_wrap;
            // Disable only takes hold at a boundary so the period completes.
            if (w_wrap && !ch_en[gi]) begin
              r_running <= 1'b0;
            end
          end
        end
      end

      assign clk_out[gi]     = r_clk;
      assign tick[gi]        = r_tick;
      assign cfg_pending[gi] = r_pend;
    end
  endgenerate

endmodule

// File: tb/tb_multi_ch_clk_div.sv
// ---------------------------------------------------------------------------
// tb_multi_ch_clk_div
//   Directed scenarios followed by randomized traffic. The reference model
//   works one whole period at a time: when a channel starts a period it
//   queues that period's complete waveform (duty+1 lows, the rest high, tick
//   on the last sample), and each clock simply pops the next sample. Configs
//   are swapped only when a period's last sample is consumed or while idle.
// ---------------------------------------------------------------------------
module tb_multi_ch_clk_div;

  localparam int CNT_W      = 26;
  localparam int N_CH       = 4;
  localparam int CH_W       = 2;
  localparam int DEF_PERIOD = 5;
  localparam int DEF_DUTY   = 2;

  logic              rst_n;
  logic              clk_in;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duty;
  logic [N_CH-1:0]   ch_en;
  logic              sync_start;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   cfg_pending;

  multi_ch_clk_div #(
    .CNT_W(CNT_W), .N_CH(N_CH), .CH_W(CH_W),
    .DEF_PERIOD(DEF_PERIOD), .DEF_DUTY(DEF_DUTY)
  ) dut (
    .rst_n(rst_n), .clk_in(clk_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .ch_en(ch_en),
    .sync_start(sync_start), .clk_out(clk_out), .tick(tick),
    .cfg_pending(cfg_pending)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=0x%0h exp=0x%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]     wave_q [N_CH][$];   // {tick, clk} per upcoming cycle
  int             pend_p [N_CH][$];
  int             pend_d [N_CH][$];
  int             act_p  [N_CH];
  int             act_d  [N_CH];
  bit             m_run  [N_CH];
  logic [N_CH-1:0] exp_clk, exp_tick, exp_pend;

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      wave_q[c].delete();
      pend_p[c].delete();
      pend_d[c].delete();
      act_p[c] = DEF_PERIOD;
      act_d[c] = DEF_DUTY;
      m_run[c] = 1'b0;
    end
    exp_clk  = '0;
    exp_tick = '0;
    exp_pend = '0;
  endfunction

  // Queue one full period of waveform for the channel's active config.
  function automatic void load_period(int c);
    int p;
    int lows;
    logic [1:0] s;
    p    = act_p[c];
    lows = (act_d[c] < p) ? act_d[c] + 1 : p + 1;
    for (int k = 0; k <= p; k++) begin
      s = {(k == p), (k >= lows)};
      wave_q[c].push_back(s);
    end
  endfunction

  function automatic void apply_cfg(int c, bit wr, int p, int d);
    if (wr) begin
      act_p[c] = p;
      act_d[c] = d;
    end else if (pend_p[c].size() > 0) begin
      act_p[c] = pend_p[c][$];
      act_d[c] = pend_d[c][$];
    end
    pend_p[c].delete();
    pend_d[c].delete();
  endfunction

  function automatic void model_step(bit we, int ch, int p, int d,
                                     logic [N_CH-1:0] en, bit sync);
    logic [1:0] s;
    bit wr;
    for (int c = 0; c < N_CH; c++) begin
      wr = we && (ch == c);
      if (sync || !m_run[c]) begin
        wave_q[c].delete();
        exp_clk[c]  = 1'b0;
        exp_tick[c] = 1'b0;
        apply_cfg(c, wr, p, d);
        m_run[c] = en[c];
        if (en[c]) load_period(c);
      end else begin
        s = wave_q[c].pop_front();
        exp_clk[c]  = s[0];
        exp_tick[c] = s[1];
        if (s[1]) begin
          apply_cfg(c, wr, p, d);
          if (en[c]) load_period(c);
          else m_run[c] = 1'b0;
        end else if (wr) begin
          pend_p[c].push_back(p);
          pend_d[c].push_back(d);
        end
      end
      exp_pend[c] = (pend_p[c].size() != 0);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs (we are at a falling edge), advance the model,
  // then compare all outputs at the next falling edge.
  task automatic cycle(input bit we, input int ch, input int p, input int d,
                       input logic [N_CH-1:0] en, input bit sync);
    logic [CH_W-1:0] ch_bits;
    ch_bits    = ch[CH_W-1:0];
    cfg_we     = we;
    cfg_ch     = ch_bits;
    cfg_period = CNT_W'(p);
    cfg_duty   = CNT_W'(d);
    ch_en      = en;
    sync_start = sync;
    model_step(we, ch, p, d, en, sync);
    @(negedge clk_in);
    chk("clk_out", 32'(clk_out), 32'(exp_clk));
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("cfg_pending", 32'(cfg_pending), 32'(exp_pend));
  endtask

  task automatic idle_cycles(input int n, input logic [N_CH-1:0] en);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, en, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_clk_out", 32'(clk_out), 32'(exp_clk));
    chk("rst_tick", 32'(tick), 32'(exp_tick));
    chk("rst_pending", 32'(cfg_pending), 32'(exp_pend));
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic phase_done(input string name);
    $display("phase %s checks=%0d failures=%0d", name, n_checks, n_fail);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [N_CH-1:0] en_r;
    bit   we_r, sync_r;
    n_checks   = 0;
    n_fail     = 0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_duty   = '0;
    ch_en      = '0;
    sync_start = 1'b0;
    do_reset();
    phase_done("reset");

    // Default div-6 on channel 0 only.
    idle_cycles(20, 4'b0001);
    phase_done("default_div6");

    // Mid-period write on ch0, held pending until the wrap.
    idle_cycles(2, 4'b0001);
    cycle(1'b1, 0, 9, 4, 4'b0001, 1'b0);
    idle_cycles(30, 4'b0001);
    phase_done("ch0_p9_d4");

    // ch1 degenerate configs: D >= P, then P = 0.
    cycle(1'b1, 1, 3, 3, 4'b0011, 1'b0);
    idle_cycles(12, 4'b0011);
    cycle(1'b1, 1, 0, 0, 4'b0011, 1'b0);
    idle_cycles(10, 4'b0011);
    phase_done("ch1_degenerate");

    // Drop ch0 enable just after a wrap, let the period finish, re-enable.
    for (int i = 0; i < 12 && !exp_tick[0]; i++) cycle(1'b0, 0, 0, 0, 4'b0011, 1'b0);
    chk("wrap_seen", 32'(tick[0]), 32'd1);
    cycle(1'b0, 0, 0, 0, 4'b0010, 1'b0);
    idle_cycles(15, 4'b0010);
    idle_cycles(15, 4'b0011);
    phase_done("ch0_disable_reenable");

    // ch0 P=5, ch2 P=11 at arbitrary phase, then realign with sync_start.
    cycle(1'b1, 0, 5, 2, 4'b0001, 1'b0);
    idle_cycles(3, 4'b0001);
    cycle(1'b1, 2, 11, 5, 4'b0101, 1'b0);
    idle_cycles($urandom_range(3, 9), 4'b0101);
    cycle(1'b0, 0, 0, 0, 4'b0101, 1'b1);
    chk("sync_low", 32'(clk_out & 4'b0101), 32'd0);
    idle_cycles(30, 4'b0101);
    phase_done("sync_align");

    // Reset during a high phase with a write still pending.
    for (int i = 0; i < 12 && !exp_clk[0]; i++) cycle(1'b0, 0, 0, 0, 4'b0101, 1'b0);
    chk("mid_high", 32'(clk_out[0]), 32'd1);
    cycle(1'b1, 0, 7, 1, 4'b0101, 1'b0);
    do_reset();
    idle_cycles(20, 4'b0001);
    phase_done("reset_mid_high");

    // Randomized traffic.
    en_r = 4'b1111;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 19) == 0) en_r[$urandom_range(0, N_CH-1)] ^= 1'b1;
        we_r   = ($urandom_range(0, 3) == 0);
        sync_r = ($urandom_range(0, 49) == 0);
        cycle(we_r, int'($urandom_range(0, N_CH-1)), int'($urandom_range(0, 12)),
              int'($urandom_range(0, 14)), en_r, sync_r);
      end
    end
    phase_done("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
